// File: rtl/fsac_filter_ctrl_pkg.sv
// ============================================================================
//  fsac_filter_ctrl_pkg
//  Types, constants and helpers shared by the filter controller RTL.
//  Revision: 1.0
// ============================================================================
`default_nettype none
`include "fsac_defines.vh"

package fsac_filter_ctrl_pkg;

  localparam logic [7:0] ADDR_ID     = `FSAC_ADDR_ID;
  localparam logic [7:0] ADDR_TARGET = `FSAC_ADDR_TARGET;
  localparam logic [7:0] ADDR_ACTIVE = `FSAC_ADDR_ACTIVE;
  localparam logic [7:0] ADDR_STATUS = `FSAC_ADDR_STATUS;
  localparam logic [7:0] ADDR_BREAK  = `FSAC_ADDR_BREAK;
  localparam logic [7:0] ADDR_SETTLE = `FSAC_ADDR_SETTLE;

  localparam int STAT_BUSY     = `FSAC_STAT_BUSY;
  localparam int STAT_PENDING  = `FSAC_STAT_PENDING;
  localparam int STAT_OVERRUN  = `FSAC_STAT_OVERRUN;
  localparam int STAT_BAD_ADDR = `FSAC_STAT_BAD_ADDR;

  typedef enum logic [1:0] {
    ST_IDLE  = `FSAC_ST_IDLE,
    ST_BREAK = `FSAC_ST_BREAK,
    ST_MAKE  = `FSAC_ST_MAKE
  } state_t;

  // Assemble the STATUS read value; upper nibble reads as zero.
  function automatic logic [7:0] status_byte(input logic busy,
                                             input logic pending,
                                             input logic overrun,
                                             input logic bad_addr);
    logic [7:0] s;
    s                = 8'h00;
    s[STAT_BUSY]     = busy;
    s[STAT_PENDING]  = pending;
    s[STAT_OVERRUN]  = overrun;
    s[STAT_BAD_ADDR] = bad_addr;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fsac_defines.vh
// ============================================================================
//  fsac_defines.vh
//  Shared constants for the fsac filter controller: register addresses,
//  STATUS bit positions and switch-sequencer state encodings.
//  Revision: 1.0
// ============================================================================
`ifndef FSAC_DEFINES_VH
`define FSAC_DEFINES_VH

// Register addresses
`define FSAC_ADDR_ID       8'h00
`define FSAC_ADDR_TARGET   8'h01
`define FSAC_ADDR_ACTIVE   8'h02
`define FSAC_ADDR_STATUS   8'h03
`define FSAC_ADDR_BREAK    8'h04
`define FSAC_ADDR_SETTLE   8'h05

// STATUS register bit indices
`define FSAC_STAT_BUSY     0
`define FSAC_STAT_PENDING  1
`define FSAC_STAT_OVERRUN  2
`define FSAC_STAT_BAD_ADDR 3

// Switch sequencer state encodings
`define FSAC_ST_IDLE       2'd0
`define FSAC_ST_BREAK      2'd1
`define FSAC_ST_MAKE       2'd2

`endif

// File: rtl/fsac_tick_gen.sv
// ============================================================================
//  fsac_tick_gen
//  Free-running prescaler: counts 0..TICK_DIV-1 and asserts tick for one
//  cycle while the count sits at its last value (i.e. on the wrap).
//  Ports:
//    sys_clk_25m  in   system clock
//    sys_rst      in   asynchronous active-high reset
//    tick         out  one-cycle pulse every TICK_DIV cycles
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fsac_tick_gen #(
  parameter int unsigned TICK_DIV = 25
) (
  input  logic sys_clk_25m,
  input  logic sys_rst,
  output logic tick
);

  localparam logic [15:0] C_LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == C_LAST) ? 16'd0 : cnt_q + 16'd1;
  end

  always_ff @(posedge sys_clk_25m or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/fsac_filter_ctrl.sv
// ============================================================================
//  fsac_filter_ctrl
//  Register bank behind the SPI slave plus a break-before-make sequencer for
//  the 8-bit filter relay bank: open all relays, wait BREAK_TICKS, apply the
//  target pattern, wait SETTLE_TICKS, then return to idle.
//  Ports:
//    sys_clk_25m    in   system clock
//    sys_rst        in   asynchronous active-high reset
//    spi_reg_addr   in   register address, qualified by spi_sel_end
//    spi_wr_data    in   write data, qualified by spi_sel_end & !spi_rw
//    spi_rw         in   1 = read, 0 = write
//    spi_sel_end    in   one-cycle access strobe
//    spi_rd_data    out  registered read data (held until the next read)
//    spi_rd_valid   out  one-cycle pulse, cycle after a read strobe
//    filter_switch  out  registered relay drive
//    busy           out  sequencer not idle
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fsac_filter_ctrl
  import fsac_filter_ctrl_pkg::*;
#(
  parameter logic [7:0]  ID_VALUE   = 8'hA5,
  parameter int unsigned TICK_DIV   = 25,
  parameter logic [7:0]  BREAK_RST  = 8'd10,
  parameter logic [7:0]  SETTLE_RST = 8'd50
) (
  input  logic       sys_clk_25m,
  input  logic       sys_rst,
  input  logic [7:0] spi_reg_addr,
  input  logic [7:0] spi_wr_data,
  input  logic       spi_rw,
  input  logic       spi_sel_end,
  output logic [7:0] spi_rd_data,
  output logic       spi_rd_valid,
  output logic [7:0] filter_switch,
  output logic       busy
);

  logic tick;

  fsac_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .sys_clk_25m (sys_clk_25m),
    .sys_rst     (sys_rst),
    .tick        (tick)
  );

  state_t     state_q,    state_d;
  logic [7:0] cnt_q,      cnt_d;
  logic [7:0] switch_q,   switch_d;
  logic [7:0] target_q,   target_d;
  logic [7:0] brk_q,      brk_d;
  logic [7:0] settle_q,   settle_d;
  logic       pending_q,  pending_d;
  logic       overrun_q,  overrun_d;
  logic       bad_q,      bad_d;
  logic [7:0] rd_data_q,  rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       busy_q,     busy_d;

  logic wr_en;
  logic rd_en;
  logic wr_target;
  logic cnt_done;

  assign wr_en     = spi_sel_end & ~spi_rw;
  assign rd_en     = spi_sel_end &  spi_rw;
  assign wr_target = wr_en && (spi_reg_addr == ADDR_TARGET);

  // A phase ends on the tick that takes the counter from 1 to 0, or at once
  // if the phase was entered with a zero count.
  assign cnt_done  = (cnt_q == 8'd0) || (tick && (cnt_q == 8'd1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    switch_d   = switch_q;
    target_d   = target_q;
    brk_d      = brk_q;
    settle_d   = settle_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    bad_d      = bad_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    // Register writes. ID and ACTIVE are read-only and silently ignore writes.
    if (wr_en) begin
      case (spi_reg_addr)
        ADDR_ID, ADDR_ACTIVE: ;
        ADDR_TARGET: target_d = spi_wr_data;
        ADDR_BREAK:  brk_d    = spi_wr_data;
        ADDR_SETTLE: settle_d = spi_wr_data;
        ADDR_STATUS: begin
          if (spi_wr_data[STAT_OVERRUN])  overrun_d = 1'b0;
          if (spi_wr_data[STAT_BAD_ADDR]) bad_d     = 1'b0;
        end
        default:     bad_d    = 1'b1;
      endcase
    end

    // A retarget during a sequence is queued; evaluated after the clear
    // above so a same-cycle set wins.
    if (wr_target && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
      overrun_d = 1'b1;
    end

    if (rd_en) begin
      rd_valid_d = 1'b1;
      case (spi_reg_addr)
        ADDR_ID:     rd_data_d = ID_VALUE;
        ADDR_TARGET: rd_data_d = target_q;
        ADDR_ACTIVE: rd_data_d = switch_q;
        ADDR_STATUS: rd_data_d = status_byte(busy_q, pending_q, overrun_q, bad_q);
        ADDR_BREAK:  rd_data_d = brk_q;
        ADDR_SETTLE: rd_data_d = settle_q;
        default:     rd_data_d = 8'h00;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_target && (spi_wr_data != switch_q)) begin
          state_d  = ST_BREAK;
          switch_d = 8'h00;
          cnt_d    = brk_q;
        end
      end
      ST_BREAK: begin
        if (cnt_done) begin
          // target_d so a same-cycle retarget is applied rather than lost.
          state_d   = ST_MAKE;
          switch_d  = target_d;
          cnt_d     = settle_q;
          pending_d = 1'b0;
        end else if (tick) begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_MAKE: begin
        if (cnt_done) begin
          if (pending_d) begin
            state_d   = ST_BREAK;
            switch_d  = 8'h00;
            cnt_d     = brk_q;
            pending_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tick) begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        switch_d = 8'h00;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge sys_clk_25m or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      switch_q   <= 8'h00;
      target_q   <= 8'h00;
      brk_q      <= BREAK_RST;
      settle_q   <= SETTLE_RST;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      bad_q      <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      switch_q   <= switch_d;
      target_q   <= target_d;
      brk_q      <= brk_d;
      settle_q   <= settle_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      bad_q      <= bad_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign spi_rd_data   = rd_data_q;
  assign spi_rd_valid  = rd_valid_q;
  assign filter_switch = switch_q;
  assign busy          = busy_q;

endmodule

`default_nettype wire
